// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: FSM state type,
// opcode/funct constants, ALU operation codes and datapath mux encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTE,
    ALUWB,
    BRANCH,
    ADDIEXEC,
    ADDIWB,
    JUMP
  } state_t;

  // instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // instruction[5:0] for R-type
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUB_REG    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller_if.sv
// Memory port handshake between the control unit and memory.
//   mem_req   : access request, held until mem_ready
//   mem_write : write qualifier for mem_req
//   iord      : 0 = PC addresses memory, 1 = ALUOut addresses memory
//   mem_ready : memory accepted/completed the access this cycle
interface mc_controller_if;
  logic mem_req;
  logic mem_write;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_write, input iord, output mem_ready);
endinterface

// File: rtl/mc_alu_decoder.sv
// R-type funct decoder.
//   funct       : instruction[5:0]
//   alu_control : ALU operation (add on unknown funct)
//   illegal     : funct is not a supported R-type operation
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing one instruction over
// 3-5 steps on a shared memory port and ALU, stalling on mem_ready.
// Ports: clk, reset (async, active-low), mem (memory handshake, master),
//   operation_code/funct/zero from the datapath, and all datapath selects
//   and strobes; illegal pulses on an unsupported opcode or funct.
// Optional: define MC_PERF_CNT_EN to add cycle_cnt / instret_cnt outputs.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  mc_controller_if.master      mem,
  input  logic [5:0]           operation_code,
  input  logic [5:0]           funct,
  input  logic                 zero,
  output logic                 ir_write,
  output logic                 pc_en,
  output logic [1:0]           pc_src,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_control,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
`ifdef MC_PERF_CNT_EN
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instret_cnt,
`endif
  output logic                 illegal
);

  state_t     state_q, state_d;
  logic [2:0] fn_alu_control;
  logic       fn_illegal;

  mc_alu_decoder u_alu_decoder (
    .funct       (funct),
    .alu_control (fn_alu_control),
    .illegal     (fn_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mem.mem_req   = 1'b0;
    mem.mem_write = 1'b0;
    mem.iord      = 1'b0;
    ir_write      = 1'b0;
    pc_en         = 1'b0;
    pc_src        = PC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_REG;
    alu_control   = '0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal       = 1'b0;

    case (state_q)
      FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_b   = ALUB_FOUR;
        alu_control = ALU_ADD;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        alu_src_b   = ALUB_IMM_SH;
        alu_control = ALU_ADD;
        case (operation_code)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = ALUB_IMM;
        alu_control = ALU_ADD;
        state_d     = (operation_code == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        if (mem.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem.mem_req   = 1'b1;
        mem.mem_write = 1'b1;
        mem.iord      = 1'b1;
        if (mem.mem_ready) state_d = FETCH;
      end
      EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_src_b   = ALUB_REG;
        alu_control = fn_alu_control;
        illegal     = fn_illegal;
        state_d     = fn_illegal ? FETCH : ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_src_b   = ALUB_REG;
        alu_control = ALU_SUB;
        pc_src      = PC_ALUOUT;
        pc_en       = zero;
        state_d     = FETCH;
      end
      ADDIEXEC: begin
        alu_src_a   = 1'b1;
        alu_src_b   = ALUB_IMM;
        alu_control = ALU_ADD;
        state_d     = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      JUMP: begin
        pc_src  = PC_JUMP;
        pc_en   = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // State already sits at FETCH during reset, but nothing may be driven
    // until reset is released, so every output is forced low here.
    if (!reset) begin
      mem.mem_req   = 1'b0;
      mem.mem_write = 1'b0;
      mem.iord      = 1'b0;
      ir_write      = 1'b0;
      pc_en         = 1'b0;
      pc_src        = '0;
      alu_src_a     = 1'b0;
      alu_src_b     = '0;
      alu_control   = '0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      illegal       = 1'b0;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;
  logic             retire;

  // Only completion states retire; illegal paths reach FETCH from
  // DECODE/EXECUTE and are excluded by construction.
  always_comb begin
    retire        = (state_d == FETCH) &&
                    (state_q inside {MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP});
    cycle_cnt_d   = cycle_cnt_q + CNT_W'(1);
    instret_cnt_d = retire ? instret_cnt_q + CNT_W'(1) : instret_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;
  import mc_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic [5:0] operation_code;
  logic [5:0] funct;
  logic       zero;
  logic       ir_write, pc_en, alu_src_a, reg_dst, mem_to_reg, reg_write, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_control;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
  logic [31:0] cyc0, ins0;
`endif

  mc_controller_if mem_if ();

  mc_controller #(.CNT_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem            (mem_if),
    .operation_code (operation_code),
    .funct          (funct),
    .zero           (zero),
    .ir_write       (ir_write),
    .pc_en          (pc_en),
    .pc_src         (pc_src),
    .alu_src_a      (alu_src_a),
    .alu_src_b      (alu_src_b),
    .alu_control    (alu_control),
    .reg_dst        (reg_dst),
    .mem_to_reg     (mem_to_reg),
    .reg_write      (reg_write),
`ifdef MC_PERF_CNT_EN
    .cycle_cnt      (cycle_cnt),
    .instret_cnt    (instret_cnt),
`endif
    .illegal        (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mem_req, mem_write, iord, ir_write, pc_en, pc_src[1:0], alu_src_a,
  //  alu_src_b[1:0], alu_control[2:0], reg_dst, mem_to_reg, reg_write, illegal}
  logic [16:0] obs;
  assign obs = {mem_if.mem_req, mem_if.mem_write, mem_if.iord, ir_write, pc_en,
                pc_src, alu_src_a, alu_src_b, alu_control, reg_dst, mem_to_reg,
                reg_write, illegal};

  localparam logic [16:0] E_RST  = 17'b0_0_0_0_0_00_0_00_000_0_0_0_0;
  localparam logic [16:0] F_WAIT = 17'b1_0_0_0_0_00_0_01_010_0_0_0_0;
  localparam logic [16:0] F_RDY  = 17'b1_0_0_1_1_00_0_01_010_0_0_0_0;
  localparam logic [16:0] DEC    = 17'b0_0_0_0_0_00_0_11_010_0_0_0_0;
  localparam logic [16:0] DEC_IL = 17'b0_0_0_0_0_00_0_11_010_0_0_0_1;
  localparam logic [16:0] MADR   = 17'b0_0_0_0_0_00_1_10_010_0_0_0_0;
  localparam logic [16:0] MRD    = 17'b1_0_1_0_0_00_0_00_000_0_0_0_0;
  localparam logic [16:0] MWB    = 17'b0_0_0_0_0_00_0_00_000_0_1_1_0;
  localparam logic [16:0] MWR    = 17'b1_1_1_0_0_00_0_00_000_0_0_0_0;
  localparam logic [16:0] EX_SUB = 17'b0_0_0_0_0_00_1_00_110_0_0_0_0;
  localparam logic [16:0] EX_IL  = 17'b0_0_0_0_0_00_1_00_010_0_0_0_1;
  localparam logic [16:0] AWB    = 17'b0_0_0_0_0_00_0_00_000_1_0_1_0;
  localparam logic [16:0] BR_Z1  = 17'b0_0_0_0_1_01_1_00_110_0_0_0_0;
  localparam logic [16:0] BR_Z0  = 17'b0_0_0_0_0_01_1_00_110_0_0_0_0;
  localparam logic [16:0] AIEX   = 17'b0_0_0_0_0_00_1_10_010_0_0_0_0;
  localparam logic [16:0] AIWB   = 17'b0_0_0_0_0_00_0_00_000_0_0_1_0;
  localparam logic [16:0] JMP    = 17'b0_0_0_0_1_10_0_00_000_0_0_0_0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Each instruction task starts with the DUT in FETCH at the next negedge.
  task automatic test_reset();
    logic [16:0] ev [4];
    reset = 1'b0; mem_if.mem_ready = 1'b1;
    operation_code = OP_RTYPE; funct = FN_SUB; zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (obs !== E_RST) begin
        n_bad++; $display("FAIL reset_hold cyc%0d: got %b want %b", i, obs, E_RST);
      end
    end
    @(negedge clk); reset = 1'b1; mem_if.mem_ready = 1'b0; #1;
    n_cmp++;
    if (obs !== F_WAIT) begin
      n_bad++; $display("FAIL reset_release: got %b want %b", obs, F_WAIT);
    end
    // R-type aborted by reset while in ALUWB
    ev = '{F_RDY, DEC, EX_SUB, AWB};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_if.mem_ready = 1'b1; #1;
      n_cmp++;
      if (obs !== ev[i]) begin
        n_bad++; $display("FAIL abort_rtype cyc%0d: got %b want %b", i, obs, ev[i]);
      end
    end
    reset = 1'b0; #1;
    n_cmp++;
    if (reg_write !== 1'b0 || obs !== E_RST) begin
      n_bad++; $display("FAIL abort_async: got %b want %b", obs, E_RST);
    end
    @(negedge clk); reset = 1'b1; mem_if.mem_ready = 1'b0; #1;
    n_cmp++;
    if (obs !== F_WAIT) begin
      n_bad++; $display("FAIL abort_release: got %b want %b", obs, F_WAIT);
    end
  endtask

  task automatic test_lw();
    logic [16:0] ev [7];
    logic        rd [7];
    int unsigned writes = 0;
    ev = '{F_RDY, DEC, MADR, MRD, MRD, MRD, MWB};
    rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    operation_code = OP_LW;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); mem_if.mem_ready = rd[i]; #1;
      if (reg_write === 1'b1) writes++;
      n_cmp++;
      if (obs !== ev[i]) begin
        n_bad++; $display("FAIL lw cyc%0d: got %b want %b", i, obs, ev[i]);
      end
    end
    n_cmp++;
    if (writes != 1) begin
      n_bad++; $display("FAIL lw_writes: got %0d want 1", writes);
    end
  endtask

  task automatic test_sw();
    logic [16:0] ev [7];
    logic        rd [7];
    int unsigned irw = 0;
    ev = '{F_WAIT, F_WAIT, F_WAIT, F_RDY, DEC, MADR, MWR};
    rd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    operation_code = OP_SW;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); mem_if.mem_ready = rd[i]; #1;
      if (ir_write === 1'b1) irw++;
      n_cmp++;
      if (obs !== ev[i]) begin
        n_bad++; $display("FAIL sw cyc%0d: got %b want %b", i, obs, ev[i]);
      end
    end
    n_cmp++;
    if (irw != 1) begin
      n_bad++; $display("FAIL sw_ir_write_pulses: got %0d want 1", irw);
    end
  endtask

  task automatic test_beq();
    logic [16:0] ev [3];
    operation_code = OP_BEQ;
    for (int z = 1; z >= 0; z--) begin
      zero = (z == 1);
      ev = '{F_RDY, DEC, (z == 1) ? BR_Z1 : BR_Z0};
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); mem_if.mem_ready = 1'b1; #1;
        n_cmp++;
        if (obs !== ev[i]) begin
          n_bad++; $display("FAIL beq_z%0d cyc%0d: got %b want %b", z, i, obs, ev[i]);
        end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_rtype();
    logic [16:0] ev [4];
    operation_code = OP_RTYPE;
    funct = FN_SUB;
    ev = '{F_RDY, DEC, EX_SUB, AWB};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_if.mem_ready = 1'b1; #1;
      n_cmp++;
      if (obs !== ev[i]) begin
        n_bad++; $display("FAIL rtype_sub cyc%0d: got %b want %b", i, obs, ev[i]);
      end
    end
    funct = 6'b000000;
    ev = '{F_RDY, DEC, EX_IL, F_WAIT};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_if.mem_ready = (i < 3); #1;
      n_cmp++;
      if (obs !== ev[i]) begin
        n_bad++; $display("FAIL rtype_badfunct cyc%0d: got %b want %b", i, obs, ev[i]);
      end
    end
    funct = FN_SUB;
  endtask

  task automatic test_illegal_op();
    logic [16:0] ev [3];
    ev = '{F_RDY, DEC_IL, F_WAIT};
    operation_code = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_if.mem_ready = (i == 0); #1;
`ifdef MC_PERF_CNT_EN
      if (i == 0) begin cyc0 = cycle_cnt; ins0 = instret_cnt; end
      if (i == 2) begin
        n_cmp++;
        if (cycle_cnt !== cyc0 + 32'd2 || instret_cnt !== ins0) begin
          n_bad++;
          $display("FAIL illegal_perf: got cyc+%0d ins+%0d want cyc+2 ins+0",
                   cycle_cnt - cyc0, instret_cnt - ins0);
        end
      end
`endif
      n_cmp++;
      if (obs !== ev[i]) begin
        n_bad++; $display("FAIL illegal_op cyc%0d: got %b want %b", i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] ev [7];
    logic [5:0]  op [7];
    ev = '{F_RDY, DEC, AIEX, AIWB, F_RDY, DEC, JMP};
    op = '{OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI, OP_J, OP_J, OP_J};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); mem_if.mem_ready = 1'b1; operation_code = op[i]; #1;
      n_cmp++;
      if (obs !== ev[i]) begin
        n_bad++; $display("FAIL addi_j cyc%0d: got %b want %b", i, obs, ev[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_rtype();
    test_illegal_op();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control unit for the MIPS datapath: a Moore-style FSM sequences one instruction over 3–5 steps.
- The steps share a single memory port and a single ALU.
- Memory accesses use a req/ready handshake, so the controller stalls on slow memory.
- Sits beside the multicycle data path and drives all of its mux selects and write strobes.

Parameters:
- CNT_W, 32, width of performance counters (used only with the optional feature)

Ports:
- clk, input, 1, system clock, rising edge
- reset, input, 1, asynchronous, active-low reset
- operation_code, input, 6, instruction[31:26] from the instruction register
- funct, input, 6, instruction[5:0] from the instruction register
- zero, input, 1, ALU zero flag
- mem_ready, input, 1, memory accepted/completed the current access this cycle
- mem_req, output, 1, memory access request
- mem_write, output, 1, write qualifier for mem_req
- iord, output, 1, 0 = PC addresses memory; 1 = ALUOut addresses memory
- ir_write, output, 1, load the instruction register
- pc_en, output, 1, PC load enable
- pc_src, output, 2, PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_src_a, output, 1, ALU A select: 0 = PC, 1 = register A
- alu_src_b, output, 2, ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2
- alu_control, output, 3, ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- reg_dst, output, 1, register write address select: 1 = rd, 0 = rt
- mem_to_reg, output, 1, register write data select: 1 = memory data register, 0 = ALUOut
- reg_write, output, 1, register file write enable
- illegal, output, 1, one-cycle pulse on an unsupported opcode or funct

Behaviour:
- Reset (reset = 0, asynchronous): state = FETCH; mem_req = 0; every strobe and select output = 0; illegal = 0.
- First FETCH after reset release: outputs as listed for FETCH below.
- All outputs are decoded from the state, except that the FETCH/MEMRD/MEMWR strobes are qualified by mem_ready.
- Unlisted outputs are 0 in every state.

States:
- FETCH: mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_control = add, pc_src = 00.
  - While mem_ready = 0: hold FETCH; ir_write = pc_en = 0.
  - When mem_ready = 1: ir_write = 1, pc_en = 1, next state DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_control = add (branch target into ALUOut).
  - Next state by opcode: lw/sw (100011/101011) → MEMADR; R-type (000000) → EXECUTE; beq (000100) → BRANCH; addi (001000) → ADDIEXEC; j (000010) → JUMP.
  - Any other opcode: illegal = 1, next state FETCH.
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_control = add. Next state: lw → MEMRD, sw → MEMWR.
- MEMRD: mem_req = 1, iord = 1. Hold until mem_ready = 1, then go to MEMWB.
- MEMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 1. Next state FETCH.
- MEMWR: mem_req = 1, mem_write = 1, iord = 1. Hold until mem_ready = 1, then go to FETCH.
- EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_control from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Legal funct: next state ALUWB.
  - Unknown funct: alu_control = 010, illegal = 1, next state FETCH, no write-back.
- ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Next state FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_control = sub, pc_src = 01, pc_en = zero. Next state FETCH.
- ADDIEXEC: alu_src_a = 1, alu_src_b = 10, alu_control = add. Next state ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Next state FETCH.
- JUMP: pc_src = 10, pc_en = 1. Next state FETCH.

Latency with mem_ready tied to 1:
- lw 5 cycles; sw, R-type, addi 4 cycles; beq, j 3 cycles.
- Each mem_ready = 0 cycle in a memory state adds one cycle.

Boundary conditions:
- mem_ready outside memory states is ignored.
- mem_req stays stable, with the same iord and mem_write, until mem_ready is seen; it is never dropped mid-handshake except by reset.
- Reset mid-instruction aborts it: no partial write-back, and the next cycle after release is FETCH.
- Unreachable state encodings recover to FETCH on the next clock.

Optional Feature:
- MC_PERF_CNT_EN defined: two CNT_W-bit output ports are added.
  - cycle_cnt increments every clock.
  - instret_cnt increments on entry to FETCH from any state except FETCH itself and reset.
  - Both reset to 0 and wrap modulo 2^CNT_W.
  - Illegal instructions do not count: instret_cnt increments only when the previous state is MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP.
- Undefined: ports absent, no counter logic.

Decomposition:
- Package mc_ctrl_pkg:
  - state enum type (FETCH..JUMP)
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALU_ADD/SUB/AND/OR/SLT codes
  - alu_src_b and pc_src encodings
- One sub-module, mc_alu_decoder: combinational funct → alu_control plus an illegal flag, instantiated by the FSM for the EXECUTE state.

Test Plan:
- Reset/abort: reset = 0 held 2 cycles, released; then an R-type instruction, with reset asserted low during ALUWB → reg_write drops to 0 immediately; after release, state FETCH, mem_req = 1, iord = 0.
- lw, mem_ready = 1 except 2 wait cycles in MEMRD → instruction takes 7 cycles; exactly one reg_write pulse, with mem_to_reg = 1, reg_dst = 0.
- sw with FETCH waiting 3 cycles → ir_write and pc_en each pulse exactly once, on the ready cycle; mem_write = 1 only in MEMWR; reg_write never 1.
- beq: zero = 1 → in BRANCH, pc_en = 1 and pc_src = 01; repeat with zero = 0 → pc_en = 0; both cases take 3 cycles.
- R-type: funct 100010 → EXECUTE alu_control = 110, ALUWB reg_write = 1 with reg_dst = 1. Funct 000000 → illegal pulse, FETCH next, no reg_write.
- Illegal opcode 111111 → illegal = 1 for one cycle in DECODE, FETCH next. With MC_PERF_CNT_EN: instret_cnt unchanged, cycle_cnt advanced by 2.
